mem_access_unit: RTL and testbench

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

---
 rtl/y86_pkg.sv | 47 ++++
 rtl/dmem_array.sv | 27 ++
 rtl/mem_access_unit.sv | 121 ++++++++++++
 tb/tb_mem_access_unit.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions: instruction codes, memory-unit FSM encoding and
// helpers that classify a request and pick its address and store data.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_RRMOVQ = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [3:0]  icode;
        logic [63:0] addr;
        logic [63:0] wdata;
    } mem_req_t;

    function automatic logic is_load(input logic [3:0] ic);
        return (ic == I_MRMOVQ) || (ic == I_RET) || (ic == I_POPQ);
    endfunction

    function automatic logic is_store(input logic [3:0] ic);
        return (ic == I_RMMOVQ) || (ic == I_PUSHQ) || (ic == I_CALL);
    endfunction

    function automatic mem_req_t make_req(input logic [3:0]  ic,
                                          input logic [63:0] val_e,
                                          input logic [63:0] val_a,
                                          input logic [63:0] val_p);
        mem_req_t r;
        r.icode = ic;
        r.addr  = ((ic == I_RET) || (ic == I_POPQ)) ? val_a : val_e;
        r.wdata = (ic == I_CALL) ? val_p : val_a;
        return r;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port data memory with synchronous read and write; rdata only
// changes on an enabled access so it holds the last read value.
module dmem_array #(
    parameter int unsigned DATA_W = 64,
    parameter int unsigned DEPTH  = 1024,
    localparam int unsigned ADDR_W = $clog2(DEPTH)
) (
    input  logic              clock,
    input  logic              en,
    input  logic              we,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clock) begin
        if (en) begin
            if (we) begin
                mem[addr] <= wdata;
            end
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_access_unit.sv
// Y86 memory stage: accepts one request at a time, waits WAIT_CYCLES, then
// performs the array access on the edge that enters RESP.
module mem_access_unit
    import y86_pkg::*;
#(
    parameter int unsigned DATA_W      = 64,
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_CYCLES = 1
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [3:0]        icode,
    input  logic [63:0]       val_e,
    input  logic [63:0]       val_a,
    input  logic [63:0]       val_p,
    output logic              resp_valid,
    output logic [DATA_W-1:0] val_m,
    output logic [63:0]       mem_add,
    output logic              bad_mem,
    output logic              busy
);

    localparam int unsigned ADDR_W   = $clog2(DEPTH);
    localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

    logic [1:0]        state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    mem_req_t          req_q, in_req, cur;
    logic              ld_ok_q, bad_q;
    logic [63:0]       mem_add_q;
    logic              accept, enter_resp;
    logic              cur_load, cur_store, cur_access, in_range;
    logic              arr_en, arr_we;
    logic [DATA_W-1:0] rdata;

    assign in_req = make_req(icode, val_e, val_a, val_p);
    assign accept = (state_q == ST_IDLE) && req_valid;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        enter_resp = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    cnt_d = CNT_INIT;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = ST_RESP;
                        enter_resp = 1'b1;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d    = ST_RESP;
                    enter_resp = 1'b1;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RESP: state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // With zero wait the access happens on the accept edge, so use the live request.
    assign cur        = (state_q == ST_IDLE) ? in_req : req_q;
    assign cur_load   = is_load(cur.icode);
    assign cur_store  = is_store(cur.icode);
    assign cur_access = cur_load || cur_store;
    assign in_range   = cur.addr < 64'(DEPTH);
    assign arr_en     = enter_resp && cur_access && in_range;
    assign arr_we     = arr_en && cur_store;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 4'd0;
            req_q     <= '0;
            ld_ok_q   <= 1'b0;
            mem_add_q <= 64'd0;
            bad_q     <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                req_q <= in_req;
            end
            if (enter_resp) begin
                ld_ok_q   <= cur_load && in_range;
                mem_add_q <= cur_access ? cur.addr : 64'd0;
                bad_q     <= cur_access && !in_range;
            end
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clock (clock),
        .en    (arr_en),
        .we    (arr_we),
        .addr  (cur.addr[ADDR_W-1:0]),
        .wdata (DATA_W'(cur.wdata)),
        .rdata (rdata)
    );

    // rdata is not reset; ld_ok_q masks it to zero after reset and for non-loads.
    assign val_m      = ld_ok_q ? rdata : '0;
    assign mem_add    = mem_add_q;
    assign bad_mem    = bad_q;
    assign resp_valid = (state_q == ST_RESP);
    assign req_ready  = (state_q == ST_IDLE);
    assign busy       = !req_ready;

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench: unit 1 uses defaults, unit 0 has zero wait, 32-bit data
// and 64 words. Expected responses come from a word-array reference model.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        rv [2];
    logic [3:0]  ic [2];
    logic [63:0] ve [2], va [2], vp [2];
    logic        rr [2], rsv [2], bm [2], bz [2];
    logic [63:0] ma [2];
    logic [31:0] vm0;
    logic [63:0] vm1;

    typedef struct {
        logic [63:0] vm;
        logic [63:0] ma;
        logic        bm;
        int          cyc;
    } exp_t;

    exp_t        q0 [$], q1 [$];
    exp_t        last [2];
    logic [63:0] mdl0 [64];
    logic [63:0] mdl1 [1024];
    int          cyc = 0, nvec = 0, nerr = 0;

    mem_access_unit #(.DATA_W(32), .DEPTH(64), .WAIT_CYCLES(0)) dut0 (
        .clock(clock), .reset_n(reset_n), .req_valid(rv[0]), .req_ready(rr[0]),
        .icode(ic[0]), .val_e(ve[0]), .val_a(va[0]), .val_p(vp[0]),
        .resp_valid(rsv[0]), .val_m(vm0), .mem_add(ma[0]), .bad_mem(bm[0]), .busy(bz[0])
    );

    mem_access_unit dut1 (
        .clock(clock), .reset_n(reset_n), .req_valid(rv[1]), .req_ready(rr[1]),
        .icode(ic[1]), .val_e(ve[1]), .val_a(va[1]), .val_p(vp[1]),
        .resp_valid(rsv[1]), .val_m(vm1), .mem_add(ma[1]), .bad_mem(bm[1]), .busy(bz[1])
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] req);
        nvec++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    // Reference model: word-indexed memory, out-of-range requests touch nothing.
    task automatic model(input int u, input logic [3:0] c, input logic [63:0] e,
                         input logic [63:0] a, input logic [63:0] p, output exp_t x);
        logic ld, st;
        logic [63:0] addr, data;
        int dep;
        x.vm = 0; x.ma = 0; x.bm = 0; x.cyc = 0;
        ld   = (c == 5) || (c == 9) || (c == 11);
        st   = (c == 4) || (c == 8) || (c == 10);
        dep  = (u == 1) ? 1024 : 64;
        if (ld || st) begin
            addr = (c == 9 || c == 11) ? a : e;
            data = (c == 8) ? p : a;
            x.ma = addr;
            if (addr >= 64'(dep)) x.bm = 1'b1;
            else if (st) begin
                if (u == 1) mdl1[addr[9:0]] = data;
                else mdl0[addr[5:0]] = {32'd0, data[31:0]};
            end else begin
                x.vm = (u == 1) ? mdl1[addr[9:0]] : mdl0[addr[5:0]];
            end
        end
    endtask

    task automatic issue(input int u, input logic [3:0] c, input logic [63:0] e,
                         input logic [63:0] a, input logic [63:0] p);
        exp_t x;
        int n = 0;
        @(negedge clock);
        // While the unit is busy, throw junk at it; it must be ignored.
        while (rr[u] !== 1'b1 && n < 20) begin
            rv[u] = 1'($urandom_range(0, 1));
            ic[u] = 4'($urandom);
            ve[u] = {$urandom, $urandom};
            va[u] = {$urandom, $urandom};
            vp[u] = {$urandom, $urandom};
            n++;
            @(negedge clock);
        end
        if (n >= 20) begin
            cmp("ready_timeout", 64'd0, 64'd1);
            rv[u] = 1'b0;
            return;
        end
        ic[u] = c; ve[u] = e; va[u] = a; vp[u] = p; rv[u] = 1'b1;
        model(u, c, e, a, p, x);
        x.cyc = cyc + ((u == 1) ? 2 : 1);
        if (u == 1) q1.push_back(x); else q0.push_back(x);
        @(posedge clock);
        #1 rv[u] = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 50) begin
            @(negedge clock);
            n++;
        end
        cmp("drain_timeout", 64'(q0.size() + q1.size()), 64'd0);
        @(negedge clock);
    endtask

    task automatic mon(input int u);
        exp_t x;
        logic [63:0] vm;
        int qs;
        vm = (u == 1) ? vm1 : {32'd0, vm0};
        qs = (u == 1) ? q1.size() : q0.size();
        cmp($sformatf("u%0d_busy", u), 64'(bz[u]), 64'(!rr[u]));
        if (rsv[u]) begin
            cmp($sformatf("u%0d_ready_in_resp", u), 64'(rr[u]), 64'd0);
            if (qs == 0) begin
                cmp($sformatf("u%0d_unexpected_resp", u), 64'd1, 64'd0);
            end else begin
                x = (u == 1) ? q1.pop_front() : q0.pop_front();
                cmp($sformatf("u%0d_val_m", u), vm, x.vm);
                cmp($sformatf("u%0d_mem_add", u), ma[u], x.ma);
                cmp($sformatf("u%0d_bad_mem", u), 64'(bm[u]), 64'(x.bm));
                cmp($sformatf("u%0d_resp_cycle", u), 64'(cyc), 64'(x.cyc));
                last[u] = x;
            end
        end else begin
            cmp($sformatf("u%0d_hold_val_m", u), vm, last[u].vm);
            cmp($sformatf("u%0d_hold_mem_add", u), ma[u], last[u].ma);
            cmp($sformatf("u%0d_hold_bad_mem", u), 64'(bm[u]), 64'(last[u].bm));
        end
    endtask

    always @(negedge clock) begin
        for (int u = 0; u < 2; u++) begin
            if (!reset_n) begin
                last[u].vm = 0; last[u].ma = 0; last[u].bm = 0;
            end else begin
                mon(u);
            end
        end
    end

    function automatic logic [63:0] rand_addr(input int u);
        int dep;
        int r;
        dep = (u == 1) ? 1024 : 64;
        r = $urandom_range(0, 7);
        if (r == 0) return 64'(dep) + 64'($urandom_range(0, 3));
        if (r == 1) return {1'b1, 31'($urandom), $urandom};
        return 64'($urandom_range(0, dep - 1));
    endfunction

    initial begin
        for (int u = 0; u < 2; u++) begin
            rv[u] = 0; ic[u] = 0; ve[u] = 0; va[u] = 0; vp[u] = 0;
        end
        // Simulation image: word i = 2*(i+1) for i < 26, the rest zero.
        for (int i = 0; i < 1024; i++) begin
            mdl1[i] = (i < 26) ? 64'(2 * (i + 1)) : 64'd0;
            dut1.u_array.mem[i] = mdl1[i];
        end
        for (int i = 0; i < 64; i++) begin
            mdl0[i] = (i < 26) ? 64'(2 * (i + 1)) : 64'd0;
            dut0.u_array.mem[i] = mdl0[i][31:0];
        end

        repeat (3) @(negedge clock);
        for (int u = 0; u < 2; u++) begin
            cmp("reset_ready", 64'(rr[u]), 64'd1);
            cmp("reset_resp_valid", 64'(rsv[u]), 64'd0);
            cmp("reset_mem_add", ma[u], 64'd0);
            cmp("reset_bad_mem", 64'(bm[u]), 64'd0);
            cmp("reset_busy", 64'(bz[u]), 64'd0);
        end
        cmp("reset_val_m1", vm1, 64'd0);
        cmp("reset_val_m0", 64'(vm0), 64'd0);
        reset_n = 1'b1;

        issue(1, 4'd5, 64'd3, 64'd0, 64'd0);
        drain();
        cmp("load_word3", vm1, 64'd8);
        issue(1, 4'd4, 64'd7, 64'hAB, 64'd0);
        issue(1, 4'd5, 64'd7, 64'd0, 64'd0);
        drain();
        cmp("store_then_load", vm1, 64'hAB);
        issue(1, 4'd10, 64'd1024, 64'h55, 64'd0);
        drain();
        cmp("bad_addr_flag", 64'(bm[1]), 64'd1);
        issue(1, 4'd5, 64'd0, 64'd0, 64'd0);
        drain();
        cmp("word0_intact", vm1, 64'd2);
        issue(1, 4'd8, 64'd20, 64'd0, 64'h40);
        issue(1, 4'd9, 64'd0, 64'd20, 64'd0);
        drain();
        cmp("call_then_ret", vm1, 64'h40);

        // Abort a store in WAIT with reset; nothing is queued for it.
        @(negedge clock);
        ic[1] = 4'd4; ve[1] = 64'd5; va[1] = 64'hDEAD; rv[1] = 1'b1;
        @(posedge clock);
        #1 rv[1] = 1'b0;
        cmp("abort_in_wait", 64'(rr[1]), 64'd0);
        #1 reset_n = 1'b0;
        #1 cmp("abort_ready", 64'(rr[1]), 64'd1);
        cmp("abort_resp_valid", 64'(rsv[1]), 64'd0);
        cmp("abort_mem_add", ma[1], 64'd0);
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        issue(1, 4'd5, 64'd5, 64'd0, 64'd0);
        drain();
        cmp("abort_no_write", vm1, 64'd12);

        // Zero-wait unit, back to back, including truncation and icode 0.
        issue(0, 4'd5, 64'd3, 64'd0, 64'd0);
        issue(0, 4'd0, 64'd3, 64'd3, 64'd3);
        issue(0, 4'd4, 64'd9, 64'h1122_3344_5566_7788, 64'd0);
        issue(0, 4'd11, 64'd0, 64'd9, 64'd0);
        issue(0, 4'd4, 64'd64, 64'h77, 64'd0);
        drain();
        cmp("zero_wait_bad", 64'(bm[0]), 64'd1);

        repeat (300) begin
            int u;
            u = $urandom_range(0, 1);
            issue(u, 4'($urandom), rand_addr(u), rand_addr(u), {$urandom, $urandom});
            if ($urandom_range(0, 3) == 0) drain();
        end
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
